// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory responder and the cache controller
// that talks to it over the mstrobe/mrw/maddress/mready handshake.
//   MEM_DATA_W / MEM_ADDR_W : default data and byte-address widths
//   MRW_READ / MRW_WRITE    : mrw encoding (cache convention, 1 = read)
//   mem_state_t             : responder FSM states
package mem_pkg;

  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_ADDR_W = 32;

  localparam logic MRW_READ  = 1'b1;
  localparam logic MRW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word storage behind the main-memory responder.
// Kept separate from the FSM so it can be replaced by a vendor RAM.
//   clk   : clock, rising edge
//   clear : asynchronous, active-high; zeroes every word
//   we    : write enable for the current edge
//   idx   : word index
//   wdata : write data
//   rdata : read data for idx (combinational)
module mem_array #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/main_memory_ctrl.sv
// Main-memory responder serving cache miss fills and write-throughs.
// One request at a time; fixed access latency per direction.
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high; aborts any request, clears memory
//   mstrobe   : request valid, sampled only in IDLE
//   mrw       : 1 = read, 0 = write
//   maddress  : byte address, bits [1:0] ignored
//   mdata_in  : write data
//   mdata_out : read data, held until the next read completes
//   mready    : one-cycle completion pulse
//   busy      : high from acceptance through the mready cycle
//   err       : out-of-range address, pulses with mready
module main_memory_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W     = MEM_DATA_W,
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned READ_LAT   = 4,
  parameter int unsigned WRITE_LAT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mstrobe,
  input  logic              mrw,
  input  logic [ADDR_W-1:0] maddress,
  input  logic [DATA_W-1:0] mdata_in,
  output logic [DATA_W-1:0] mdata_out,
  output logic              mready,
  output logic              busy,
  output logic              err
);

  localparam int unsigned MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LAT - 1);

  mem_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-3:0] lat_word;
  logic              lat_rw;
  logic [DATA_W-1:0] lat_wdata;

  logic                  oor;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  last_cycle;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_rdata;

  // Byte-offset bits carry no meaning for a word-organised store.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^maddress[1:0];

  // Any word-address bit above the stored depth flags the request.
  assign oor        = |(lat_word >> DEPTH_LOG2);
  assign idx        = lat_word[DEPTH_LOG2-1:0];
  assign last_cycle = (state == ST_ACCESS) && (cnt == '0);
  assign mem_we     = last_cycle && (lat_rw == MRW_WRITE) && !oor;

  mem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .clear (reset),
    .we    (mem_we),
    .idx   (idx),
    .wdata (lat_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_word  <= '0;
      lat_rw    <= MRW_WRITE;
      lat_wdata <= '0;
      mdata_out <= '0;
      mready    <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          mready <= 1'b0;
          err    <= 1'b0;
          if (mstrobe) begin
            lat_word  <= maddress[ADDR_W-1:2];
            lat_rw    <= mrw;
            lat_wdata <= mdata_in;
            cnt       <= (mrw == MRW_READ) ? RD_LOAD : WR_LOAD;
            busy      <= 1'b1;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // The write itself is committed by mem_array on this same edge.
            mready <= 1'b1;
            err    <= oor;
            state  <= ST_RESPOND;
            if (lat_rw == MRW_READ) begin
              mdata_out <= oor ? '0 : mem_rdata;
            end
          end
        end
        ST_RESPOND: begin
          mready <= 1'b0;
          err    <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench for main_memory_ctrl with a behavioural memory model.
module tb_main_memory_ctrl;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 32;
  localparam int unsigned DL2  = 12;
  localparam int          RLAT = 4;
  localparam int          WLAT = 4;
  localparam int          NWORDS = 1 << DL2;

  logic          clk;
  logic          reset;
  logic          mstrobe;
  logic          mrw;
  logic [AW-1:0] maddress;
  logic [DW-1:0] mdata_in;
  logic [DW-1:0] mdata_out;
  logic          mready;
  logic          busy;
  logic          err;

  int n_cmp;
  int n_bad;

  // Behavioural model: word array plus the last value a read delivered.
  logic [DW-1:0] mdl_mem [NWORDS];
  logic [DW-1:0] mdl_rdata;

  main_memory_ctrl #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .DEPTH_LOG2 (DL2),
    .READ_LAT   (RLAT),
    .WRITE_LAT  (WLAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mstrobe   (mstrobe),
    .mrw       (mrw),
    .maddress  (maddress),
    .mdata_in  (mdata_in),
    .mdata_out (mdata_out),
    .mready    (mready),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < NWORDS; i++) mdl_mem[i] = '0;
    mdl_rdata = '0;
  endtask

  // Applies one request to the model; returns expected mdata_out and err.
  task automatic model_access(input logic rw, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data,
                              output logic [DW-1:0] exp_d, output logic exp_e);
    logic inr;
    int   w;
    inr = (addr / (4 * NWORDS)) == 0;
    w   = int'((addr / 4) % NWORDS);
    if (rw) begin
      mdl_rdata = inr ? mdl_mem[w] : '0;
    end else if (inr) begin
      mdl_mem[w] = data;
    end
    exp_d = mdl_rdata;
    exp_e = !inr;
  endtask

  // Drives one request, scrambles inputs right after acceptance, and reports
  // the cycle (1 = first cycle after the accepting edge) mready was seen.
  task automatic run_req(input logic rw, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data,
                         output int lat, output logic [DW-1:0] rdat,
                         output logic e, output logic busy_ok,
                         output logic pulse_ok);
    @(negedge clk);
    mstrobe = 1'b1; mrw = rw; maddress = addr; mdata_in = data;
    @(posedge clk);
    #1;
    mstrobe  = 1'b0;
    mrw      = 1'($urandom);
    maddress = $urandom;
    mdata_in = $urandom;
    lat = 0; rdat = '0; e = 1'b0; busy_ok = 1'b1; pulse_ok = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (mready === 1'b1) begin
        lat = k; rdat = mdata_out; e = err;
        break;
      end
    end
    if (lat != 0) begin
      @(negedge clk);
      pulse_ok = (mready === 1'b0) && (busy === 1'b0) && (err === 1'b0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mstrobe = 1'b0; mrw = 1'b0; maddress = '0; mdata_in = '0;
    model_clear();
    repeat (3) @(negedge clk);
    n_cmp++; if (mready !== 1'b0) begin n_bad++; $display("FAIL reset_mready: got %b want 0", mready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (mdata_out !== 32'h0) begin n_bad++; $display("FAIL reset_mdata_out: got %h want 0", mdata_out); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || mready !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle: busy %b mready %b want 0 0", busy, mready); end
  endtask

  task automatic test_read_latency();
    int lat; logic [DW-1:0] d, ed; logic e, ee, bok, pok;
    model_access(1'b1, 32'h0000_0010, '0, ed, ee);
    run_req(1'b1, 32'h0000_0010, '0, lat, d, e, bok, pok);
    n_cmp++; if (lat != RLAT + 1) begin n_bad++; $display("FAIL read_latency: got %0d want %0d", lat, RLAT + 1); end
    n_cmp++; if (d !== ed) begin n_bad++; $display("FAIL read_data0: got %h want %h", d, ed); end
    n_cmp++; if (e !== ee) begin n_bad++; $display("FAIL read_err0: got %b want %b", e, ee); end
    n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL read_busy: got %b want 1", bok); end
    n_cmp++; if (pok !== 1'b1) begin n_bad++; $display("FAIL read_single_pulse: got %b want 1", pok); end
  endtask

  task automatic test_write_read();
    int lat; logic [DW-1:0] d, ed; logic e, ee, bok, pok;
    model_access(1'b0, 32'h0000_0104, 32'hDEAD_BEEF, ed, ee);
    run_req(1'b0, 32'h0000_0104, 32'hDEAD_BEEF, lat, d, e, bok, pok);
    n_cmp++; if (lat != WLAT + 1) begin n_bad++; $display("FAIL write_latency: got %0d want %0d", lat, WLAT + 1); end
    n_cmp++; if (d !== ed) begin n_bad++; $display("FAIL write_keeps_rdata: got %h want %h", d, ed); end
    n_cmp++; if (pok !== 1'b1 || bok !== 1'b1) begin n_bad++; $display("FAIL write_handshake: busy_ok %b pulse_ok %b want 1 1", bok, pok); end
    model_access(1'b1, 32'h0000_0107, '0, ed, ee);
    run_req(1'b1, 32'h0000_0107, '0, lat, d, e, bok, pok);
    n_cmp++; if (d !== ed) begin n_bad++; $display("FAIL raw_data: got %h want %h", d, ed); end
    n_cmp++; if (e !== ee) begin n_bad++; $display("FAIL raw_err: got %b want %b", e, ee); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [DW-1:0] d, ed; logic e, ee, bok, pok;
    model_access(1'b0, 32'h0001_0000, 32'h1234_5678, ed, ee);
    run_req(1'b0, 32'h0001_0000, 32'h1234_5678, lat, d, e, bok, pok);
    n_cmp++; if (e !== ee) begin n_bad++; $display("FAIL oor_write_err: got %b want %b", e, ee); end
    n_cmp++; if (lat != WLAT + 1) begin n_bad++; $display("FAIL oor_write_latency: got %0d want %0d", lat, WLAT + 1); end
    model_access(1'b1, 32'h0001_0000, '0, ed, ee);
    run_req(1'b1, 32'h0001_0000, '0, lat, d, e, bok, pok);
    n_cmp++; if (e !== ee) begin n_bad++; $display("FAIL oor_read_err: got %b want %b", e, ee); end
    n_cmp++; if (d !== ed) begin n_bad++; $display("FAIL oor_read_data: got %h want %h", d, ed); end
    n_cmp++; if (pok !== 1'b1) begin n_bad++; $display("FAIL oor_err_clears: got %b want 1", pok); end
    model_access(1'b1, 32'h0000_0000, '0, ed, ee);
    run_req(1'b1, 32'h0000_0000, '0, lat, d, e, bok, pok);
    n_cmp++; if (d !== ed) begin n_bad++; $display("FAIL word0_untouched: got %h want %h", d, ed); end
  endtask

  task automatic test_latched_inputs();
    int lat; logic [DW-1:0] d, ed; logic e, ee, bok, pok;
    model_access(1'b0, 32'h0000_0300, 32'hA5A5_5A5A, ed, ee);
    run_req(1'b0, 32'h0000_0300, 32'hA5A5_5A5A, lat, d, e, bok, pok);
    model_access(1'b1, 32'h0000_0300, '0, ed, ee);
    run_req(1'b1, 32'h0000_0300, '0, lat, d, e, bok, pok);
    n_cmp++; if (d !== ed) begin n_bad++; $display("FAIL latched_write: got %h want %h", d, ed); end
  endtask

  task automatic test_random();
    int lat; logic [DW-1:0] d, ed, a, wd; logic e, ee, bok, pok, rw;
    for (int t = 0; t < 40; t++) begin
      rw = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       a = $urandom | 32'h0001_0000;
        1, 2, 3: a = 32'($urandom_range(0, 4 * NWORDS - 1));
        default: a = 32'($urandom_range(0, 63));
      endcase
      wd = $urandom;
      model_access(rw, a, wd, ed, ee);
      run_req(rw, a, wd, lat, d, e, bok, pok);
      n_cmp++; if (lat != (rw ? RLAT : WLAT) + 1) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", t, lat, (rw ? RLAT : WLAT) + 1); end
      n_cmp++; if (d !== ed) begin n_bad++; $display("FAIL rand_data[%0d] rw=%b addr=%h: got %h want %h", t, rw, a, d, ed); end
      n_cmp++; if (e !== ee) begin n_bad++; $display("FAIL rand_err[%0d] addr=%h: got %b want %b", t, a, e, ee); end
      n_cmp++; if (bok !== 1'b1 || pok !== 1'b1) begin n_bad++; $display("FAIL rand_handshake[%0d]: busy_ok %b pulse_ok %b want 1 1", t, bok, pok); end
    end
  endtask

  task automatic test_back_to_back();
    localparam int NREQ = 8;
    logic [DW-1:0] ed; logic ee, rw;
    int done, last, idle;
    done = 0; last = 0; idle = 0;
    @(negedge clk);
    rw = 1'b0;
    mstrobe = 1'b1; mrw = rw; maddress = 32'h0000_0200; mdata_in = $urandom;
    model_access(mrw, maddress, mdata_in, ed, ee);
    for (int cyc = 1; cyc <= 200 && done < NREQ; cyc++) begin
      @(negedge clk);
      if (busy === 1'b0 && done > 0) idle++;
      if (mready === 1'b1) begin
        n_cmp++; if (cyc - last != ((done == 0) ? RLAT + 1 : RLAT + 2)) begin n_bad++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", done, cyc - last, (done == 0) ? RLAT + 1 : RLAT + 2); end
        n_cmp++; if (mdata_out !== ed || err !== ee) begin n_bad++; $display("FAIL b2b_result[%0d]: got %h/%b want %h/%b", done, mdata_out, err, ed, ee); end
        done++; last = cyc;
        if (done < NREQ) begin
          rw = ~rw;
          mrw = rw; maddress = 32'h0000_0200 + 32'(4 * (done / 2)); mdata_in = $urandom;
          model_access(mrw, maddress, mdata_in, ed, ee);
        end else begin
          mstrobe = 1'b0;
        end
      end
    end
    mstrobe = 1'b0;
    n_cmp++; if (done != NREQ) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", done, NREQ); end
    n_cmp++; if (idle != NREQ - 1) begin n_bad++; $display("FAIL b2b_idle_cycles: got %0d want %0d", idle, NREQ - 1); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int lat, pulses; logic [DW-1:0] d, ed; logic e, ee, bok, pok;
    model_access(1'b0, 32'h0000_0040, 32'h1111_1111, ed, ee);
    run_req(1'b0, 32'h0000_0040, 32'h1111_1111, lat, d, e, bok, pok);
    @(negedge clk);
    mstrobe = 1'b1; mrw = 1'b0; maddress = 32'h0000_0040; mdata_in = 32'hCAFE_F00D;
    @(posedge clk);
    #1 mstrobe = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    model_clear();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || mready !== 1'b0) begin n_bad++; $display("FAIL abort_outputs: busy %b mready %b want 0 0", busy, mready); end
    reset = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (mready === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL abort_no_mready: got %0d pulses want 0", pulses); end
    model_access(1'b1, 32'h0000_0040, '0, ed, ee);
    run_req(1'b1, 32'h0000_0040, '0, lat, d, e, bok, pok);
    n_cmp++; if (d !== ed) begin n_bad++; $display("FAIL abort_mem_cleared: got %h want %h", d, ed); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_read_latency();
    test_write_read();
    test_out_of_range();
    test_latched_inputs();
    test_random();
    test_back_to_back();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
